// File: rtl/sort_check_pkg.sv
// Shared definitions for the sort-order checker: FSM encoding, word width, address step.
package sort_check_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LAT_CNT_W = 3;   // enough for READ_LATENCY up to 4
  localparam logic [WORD_W-1:0] ADDR_STEP = 32'd4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StFin
  } state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sort_order_checker_if.sv
// Control and memory-read signals of the sort-order checker.
// slave: the checker's view. master: the environment (CPU side + memory port).
interface sort_order_checker_if #(
  parameter int unsigned CNT_W = 16
);
  import sort_check_pkg::*;

  logic              start;
  logic [WORD_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  fail_index;

  modport slave (
    input  start, base_addr, count, mem_rdata,
    output mem_rd, mem_addr, busy, done, pass, fail_index
  );

  modport master (
    output start, base_addr, count, mem_rdata,
    input  mem_rd, mem_addr, busy, done, pass, fail_index
  );

endinterface

// File: rtl/sort_check_cmp.sv
// Combinational order check of two adjacent words.
// SORT_CHECK_SIGNED_EN selects two's-complement compare; otherwise unsigned.
module sort_check_cmp
  import sort_check_pkg::*;
#(
  parameter bit ALLOW_EQUAL = 1'b0
) (
  input  logic [WORD_W-1:0] prev_i,
  input  logic [WORD_W-1:0] cur_i,
  output logic              in_order_o
);

  logic greater;
  logic equal;

  // cur must exceed prev, or match it when equal neighbours are allowed
  always_comb begin
`ifdef SORT_CHECK_SIGNED_EN
    greater = $signed(cur_i) > $signed(prev_i);
`else
    greater = cur_i > prev_i;
`endif
    equal      = (cur_i == prev_i);
    in_order_o = greater | (ALLOW_EQUAL & equal);
  end

endmodule

// File: rtl/sort_order_checker.sv
// Reads count consecutive words from base_addr and reports whether they ascend.
// Optional macro SORT_CHECK_SIGNED_EN: compare words as signed (default unsigned).
module sort_order_checker
  import sort_check_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          ALLOW_EQUAL  = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  sort_order_checker_if.slave bus
);

  localparam logic [LAT_CNT_W-1:0] LastLat = LAT_CNT_W'(READ_LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]    addr_q, addr_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [WORD_W-1:0]    prev_q, prev_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     fidx_q, fidx_d;
  logic                 in_order;

  sort_check_cmp #(
    .ALLOW_EQUAL(ALLOW_EQUAL)
  ) u_cmp (
    .prev_i    (prev_q),
    .cur_i     (bus.mem_rdata),
    .in_order_o(in_order)
  );

  // Scan sequencing: latch request, issue reads, compare neighbours, finish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    prev_d  = prev_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d  = bus.count;
          addr_d = word_align(bus.base_addr);
          idx_d  = '0;
          fidx_d = '0;
          // Fewer than two words are trivially sorted
          if (bus.count < CNT_W'(2)) begin
            pass_d  = 1'b1;
            state_d = StFin;
          end else begin
            pass_d  = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LastLat) begin
          if ((idx_q != '0) && !in_order) begin
            fidx_d  = idx_q;
            pass_d  = 1'b0;
            state_d = StFin;
          end else begin
            prev_d = bus.mem_rdata;
            idx_d  = idx_q + CNT_W'(1);
            addr_d = addr_q + ADDR_STEP;  // wraps mod 2^32
            // Compare against count-1 so a full-range count cannot overflow idx
            if (idx_q == cnt_q - CNT_W'(1)) begin
              pass_d  = 1'b1;
              state_d = StFin;
            end else begin
              state_d = StReq;
            end
          end
        end else begin
          lat_d = lat_q + LAT_CNT_W'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      prev_q  <= '0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      prev_q  <= prev_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
    end
  end

  // Outputs decoded from state and held result
  always_comb begin
    bus.mem_rd     = (state_q == StReq);
    bus.mem_addr   = addr_q;
    bus.busy       = (state_q != StIdle);
    bus.done       = (state_q == StFin);
    bus.pass       = pass_q;
    bus.fail_index = fidx_q;
  end

endmodule

// File: tb/tb_sort_order_checker.sv
// Bench for sort_order_checker: three instances (L=1 strict, L=1 equal-allowed, L=3 strict)
// scan the same memory image; results are compared with a behavioural model.
module tb_sort_order_checker;

  localparam int NDUT  = 3;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       base_addr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       exp_base;

  logic [31:0] mem [logic [31:0]];

  logic             done_w   [NDUT];
  logic             busy_w   [NDUT];
  logic             pass_w   [NDUT];
  logic             mem_rd_w [NDUT];
  logic [31:0]      maddr_w  [NDUT];
  logic [CNT_W-1:0] fidx_w   [NDUT];
  int               rd_total_w   [NDUT];
  int               done_total_w [NDUT];
  int               addr_bad_w   [NDUT];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return $urandom;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic bit ae_of(input int g);
    return (g == 1);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L  = (g == 2) ? 3 : 1;
    localparam bit          AE = (g == 1);

    sort_order_checker_if #(.CNT_W(CNT_W)) bus ();
    logic [31:0] pipe [4];
    int rd_total, done_total, addr_bad, rd_idx;

    assign bus.start     = start;
    assign bus.base_addr = base_addr;
    assign bus.count     = count;
    assign bus.mem_rdata = pipe[L-1];

    sort_order_checker #(
      .READ_LATENCY(L),
      .ALLOW_EQUAL (AE),
      .CNT_W       (CNT_W)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    // Memory with L-cycle read latency; garbage when no read is in flight
    always @(posedge clk) begin
      pipe[0] <= bus.mem_rd ? mem_read(bus.mem_addr) : $urandom;
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end

    // Read/done bookkeeping; every read must hit the next word of the current scan
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_idx <= 0;
      end else begin
        if (bus.mem_rd) begin
          rd_total <= rd_total + 1;
          if (bus.mem_addr !== exp_base + 32'(4 * rd_idx)) addr_bad <= addr_bad + 1;
          rd_idx <= rd_idx + 1;
        end
        if (bus.done) begin
          done_total <= done_total + 1;
          rd_idx     <= 0;
        end
      end
    end

    assign done_w[g]       = bus.done;
    assign busy_w[g]       = bus.busy;
    assign pass_w[g]       = bus.pass;
    assign mem_rd_w[g]     = bus.mem_rd;
    assign maddr_w[g]      = bus.mem_addr;
    assign fidx_w[g]       = bus.fail_index;
    assign rd_total_w[g]   = rd_total;
    assign done_total_w[g] = done_total;
    assign addr_bad_w[g]   = addr_bad;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the words as the CPU would see them, first out-of-order index wins
  task automatic model(input logic [31:0] base, input int n, input int lat, input bit ae,
                       output bit p, output int fi, output int nr, output int cyc);
    logic [31:0] b;
    logic [31:0] a;
    logic [31:0] c;
    bit bad;
    b  = {base[31:2], 2'b00};
    p  = 1'b1;
    fi = 0;
    nr = (n < 2) ? 0 : n;
    for (int i = 1; i < n; i++) begin
      a = mem_read(b + 32'(4 * (i - 1)));
      c = mem_read(b + 32'(4 * i));
`ifdef SORT_CHECK_SIGNED_EN
      bad = ae ? ($signed(c) < $signed(a)) : ($signed(c) <= $signed(a));
`else
      bad = ae ? (c < a) : (c <= a);
`endif
      if (bad) begin
        p  = 1'b0;
        fi = i;
        nr = i + 1;
        break;
      end
    end
    cyc = (n < 2) ? 1 : nr * (lat + 1) + 1;
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] v [$]);
    for (int i = 0; i < v.size(); i++) mem[{base[31:2], 2'b00} + 32'(4 * i)] = v[i];
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("%s/d%0d/busy", tag, g), busy_w[g], 0);
      check_eq($sformatf("%s/d%0d/done", tag, g), done_w[g], 0);
      check_eq($sformatf("%s/d%0d/pass", tag, g), pass_w[g], 0);
      check_eq($sformatf("%s/d%0d/fidx", tag, g), fidx_w[g], 0);
      check_eq($sformatf("%s/d%0d/mem_rd", tag, g), mem_rd_w[g], 0);
      check_eq($sformatf("%s/d%0d/mem_addr", tag, g), maddr_w[g], 0);
    end
  endtask

  // One scan on all instances; lat counts posedges from the one sampling start
  // through the one after which done is visible.
  task automatic run_scan(input string tag, input logic [31:0] base, input int n,
                          input int poke_at, output int lat_a, output int lat_c);
    int  d0 [NDUT];
    int  r0 [NDUT];
    int  b0 [NDUT];
    int  lat [NDUT];
    bit  seen [NDUT];
    bit  all_seen;
    bit  ep;
    int  efi, enr, ecyc;
    for (int g = 0; g < NDUT; g++) begin
      d0[g] = done_total_w[g];
      r0[g] = rd_total_w[g];
      b0[g] = addr_bad_w[g];
      lat[g] = 0;
      seen[g] = 1'b0;
    end
    exp_base = {base[31:2], 2'b00};
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    count     = CNT_W'(n);
    all_seen  = 1'b0;
    for (int cyc = 1; cyc <= 300 && !all_seen; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start     = 1'b0;
        base_addr = $urandom;
        count     = CNT_W'($urandom);
        for (int g = 0; g < NDUT; g++)
          check_eq($sformatf("%s/d%0d/busy_after_start", tag, g), busy_w[g], 1);
      end
      if (poke_at > 0 && cyc == poke_at) begin
        start     = 1'b1;
        base_addr = $urandom;
        count     = CNT_W'($urandom_range(0, 3));
      end
      if (poke_at > 0 && cyc == poke_at + 1) start = 1'b0;
      all_seen = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (!seen[g] && done_w[g]) begin
          seen[g] = 1'b1;
          lat[g]  = cyc;
        end
        all_seen &= seen[g];
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      model(base, n, lat_of(g), ae_of(g), ep, efi, enr, ecyc);
      check_eq($sformatf("%s/d%0d/finished", tag, g), seen[g], 1);
      check_eq($sformatf("%s/d%0d/latency", tag, g), lat[g], ecyc);
      check_eq($sformatf("%s/d%0d/pass", tag, g), pass_w[g], ep);
      check_eq($sformatf("%s/d%0d/fail_index", tag, g), fidx_w[g], efi);
      check_eq($sformatf("%s/d%0d/reads", tag, g), rd_total_w[g] - r0[g], enr);
      check_eq($sformatf("%s/d%0d/done_pulses", tag, g), done_total_w[g] - d0[g], 1);
      check_eq($sformatf("%s/d%0d/bad_addrs", tag, g), addr_bad_w[g] - b0[g], 0);
      check_eq($sformatf("%s/d%0d/busy_end", tag, g), busy_w[g], 0);
    end
    lat_a = lat[0];
    lat_c = lat[2];
  endtask

  initial begin
    logic [31:0] q [$];
    logic [31:0] v;
    logic [31:0] base;
    int la, lc, n, mode;
    int d0 [NDUT];

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    exp_base  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_release");

    // Early failure at index 2
    q = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
    fill(512, q);
    run_scan("t1", 512, 12, 0, la, lc);
    check_eq("t1/const_latency", la, 7);
    check_eq("t1/const_fidx", fidx_w[0], 2);

    // Fully sorted
    q = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    fill(512, q);
    run_scan("t2", 512, 12, 0, la, lc);
    check_eq("t2/const_latency_l1", la, 25);
    check_eq("t2/const_latency_l3", lc, 49);
    check_eq("t2/const_pass", pass_w[0], 1);

    // Equal neighbours
    q = '{5, 5, 9};
    fill(512, q);
    run_scan("t3", 512, 3, 0, la, lc);
    check_eq("t3/const_strict_fidx", fidx_w[0], 1);
    check_eq("t3/const_equal_pass", pass_w[1], 1);

    // Sign-sensitive pair
    q = '{32'hFFFF_FFFF, 5};
    fill(512, q);
    run_scan("t4", 512, 2, 0, la, lc);

    // Degenerate counts, start while busy, misaligned base, wrapping addresses
    run_scan("t5_n0", 512, 0, 0, la, lc);
    run_scan("t5_n1", 512, 1, 0, la, lc);
    q = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    fill(512, q);
    run_scan("t5_poke", 512, 12, 3, la, lc);
    run_scan("misaligned", 515, 6, 0, la, lc);
    q = '{1, 2, 3, 4, 5};
    fill(32'hFFFF_FFF8, q);
    run_scan("wrap", 32'hFFFF_FFF8, 5, 0, la, lc);

    // Reset during the WAIT of element 4
    q = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    fill(512, q);
    exp_base = 512;
    for (int g = 0; g < NDUT; g++) d0[g] = done_total_w[g];
    @(negedge clk);
    start     = 1'b1;
    base_addr = 512;
    count     = 12;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midscan_reset");
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      check_eq($sformatf("midscan_reset/d%0d/no_done", g), done_total_w[g] - d0[g], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("after_reset", 512, 12, 0, la, lc);

    // Randomised scans
    for (int t = 0; t < 40; t++) begin
      n    = $urandom_range(0, 14);
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      else base = 32'h1000 + 32'(4 * $urandom_range(0, 64)) + 32'($urandom_range(0, 3));
      q.delete();
      v = (mode == 1) ? 32'h7FFF_FFF0 : 32'($urandom_range(0, 100));
      for (int i = 0; i < n; i++) begin
        if (mode == 0) v = $urandom;
        else v = v + 32'($urandom_range(0, 6)) - (($urandom_range(0, 9) == 0) ? 32'd10 : 32'd0);
        q.push_back(v);
      end
      fill(base, q);
      run_scan($sformatf("rand%0d", t), base, n, (n >= 2 && t % 4 == 0) ? 3 : 0, la, lc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
